// File: rtl/wishbone_pipeline_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone target among N initiators, with LOCK hold and response watchdog.
// Latency: grant registered 1 cycle after CYC in IDLE; owner's request/response paths are combinational thereafter.
// Backpressure: owner stalls on T_STALL or when MaxOutstanding requests are in flight; non-owners always stall.
module wishbone_pipeline_arbiter #(
  parameter int Initiators     = 4,
  parameter int AddressWidth   = 16,
  parameter int DataWidth      = 8,
  parameter int Granularity    = 8,
  parameter int MaxOutstanding = 4,
  parameter int Timeout        = 255,
  localparam int SELWidth      = DataWidth / Granularity
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [Initiators-1:0]              I_CYC,
  input  logic [Initiators-1:0]              I_STB,
  input  logic [Initiators-1:0]              I_WE,
  input  logic [Initiators-1:0]              I_LOCK,
  input  logic [Initiators*AddressWidth-1:0] I_ADDR,
  input  logic [Initiators*DataWidth-1:0]    I_DAT_ToTarget,
  input  logic [Initiators*SELWidth-1:0]     I_SEL,
  output logic [Initiators-1:0]              I_STALL,
  output logic [Initiators-1:0]              I_ACK,
  output logic [Initiators-1:0]              I_ERR,
  output logic [Initiators-1:0]              I_RTY,
  output logic [DataWidth-1:0]               I_DAT_ToInitiator,
  output logic                               T_CYC,
  output logic                               T_STB,
  output logic                               T_WE,
  output logic                               T_LOCK,
  output logic [AddressWidth-1:0]            T_ADDR,
  output logic [DataWidth-1:0]               T_DAT_ToTarget,
  output logic [SELWidth-1:0]                T_SEL,
  input  logic                               T_STALL,
  input  logic                               T_ACK,
  input  logic                               T_ERR,
  input  logic                               T_RTY,
  input  logic [DataWidth-1:0]               T_DAT_ToInitiator,
  output logic [Initiators-1:0]              Grant
);

  localparam int IdxW = (Initiators > 1) ? $clog2(Initiators) : 1;
  localparam int OutW = $clog2(MaxOutstanding + 1);
  localparam int WdW  = $clog2(Timeout + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] OWNED  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
  localparam logic [1:0] ABORT  = 2'd3;

  logic [1:0]            state;
  logic [Initiators-1:0] grant_q;
  logic [IdxW-1:0]       owner;
  logic [IdxW-1:0]       pointer;
  logic [OutW-1:0]       outstanding;
  logic [WdW-1:0]        watchdog;

  logic            found;
  logic [IdxW-1:0] next_idx;
  logic [IdxW-1:0] adv_ptr;
  logic            owned;
  logic            locked;
  logic            aborting;
  logic            cyc_g;
  logic            lock_g;
  logic            at_max;
  logic            accept;
  logic            resp_ok;

  assign owned    = (state == OWNED);
  assign locked   = (state == LOCKED);
  assign aborting = (state == ABORT);
  assign cyc_g    = I_CYC[owner];
  assign lock_g   = I_LOCK[owner];
  assign at_max   = (outstanding >= OutW'(MaxOutstanding));
  assign adv_ptr  = (owner == IdxW'(Initiators - 1)) ? '0 : owner + 1'b1;

  // Target side follows the owner; strobe is held back once the in-flight window is full.
  assign T_CYC          = owned & cyc_g;
  assign T_STB          = owned & cyc_g & I_STB[owner] & ~at_max;
  assign T_LOCK         = (owned | locked) & lock_g;
  assign T_WE           = I_WE[owner];
  assign T_ADDR         = I_ADDR[owner*AddressWidth +: AddressWidth];
  assign T_DAT_ToTarget = I_DAT_ToTarget[owner*DataWidth +: DataWidth];
  assign T_SEL          = I_SEL[owner*SELWidth +: SELWidth];

  assign I_DAT_ToInitiator = T_DAT_ToInitiator;
  assign Grant             = grant_q;

  // A response only counts when something is in flight; stray responses are swallowed.
  assign accept  = T_STB & ~T_STALL;
  assign resp_ok = owned & (outstanding != '0) & (T_ACK | T_ERR | T_RTY);

  // Round-robin search: first CYC requester at or after the pointer, wrapping.
  always_comb begin
    found    = 1'b0;
    next_idx = '0;
    for (int i = 0; i < Initiators; i++) begin
      if (!found && I_CYC[(int'(pointer) + i) % Initiators]) begin
        found    = 1'b1;
        next_idx = IdxW'((int'(pointer) + i) % Initiators);
      end
    end
  end

  // Per-initiator stall and response steering; ABORT synthesises one ERR per stranded request.
  always_comb begin
    I_STALL = '1;
    I_ACK   = '0;
    I_ERR   = '0;
    I_RTY   = '0;
    if (owned) begin
      I_STALL[owner] = T_STALL | at_max;
      if (resp_ok) begin
        I_ACK[owner] = T_ACK;
        I_ERR[owner] = T_ERR;
        I_RTY[owner] = T_RTY;
      end
    end else if (aborting) begin
      I_ERR[owner] = (outstanding != '0);
    end
  end

  // Ownership FSM, in-flight counter and response watchdog.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      grant_q     <= '0;
      owner       <= '0;
      pointer     <= '0;
      outstanding <= '0;
      watchdog    <= '0;
    end else begin
      case (state)
        IDLE: begin
          watchdog    <= '0;
          outstanding <= '0;
          if (found) begin
            grant_q <= {{(Initiators-1){1'b0}}, 1'b1} << next_idx;
            owner   <= next_idx;
            state   <= OWNED;
          end
        end
        OWNED: begin
          if (!cyc_g) begin
            // Dropping CYC abandons anything still in flight.
            outstanding <= '0;
            watchdog    <= '0;
            if (lock_g) begin
              state <= LOCKED;
            end else begin
              state   <= IDLE;
              grant_q <= '0;
              pointer <= adv_ptr;
            end
          end else begin
            outstanding <= outstanding + OutW'(accept) - OutW'(resp_ok);
            if (accept || resp_ok || (outstanding == '0)) begin
              watchdog <= '0;
            end else if (watchdog == WdW'(Timeout - 1)) begin
              watchdog <= WdW'(Timeout);
              state    <= ABORT;
            end else begin
              watchdog <= watchdog + 1'b1;
            end
          end
        end
        LOCKED: begin
          watchdog <= '0;
          if (cyc_g) begin
            state <= OWNED;
          end else if (!lock_g) begin
            state   <= IDLE;
            grant_q <= '0;
            pointer <= adv_ptr;
          end
        end
        ABORT: begin
          watchdog <= '0;
          if (outstanding > OutW'(1)) begin
            outstanding <= outstanding - 1'b1;
          end else begin
            outstanding <= '0;
            if (cyc_g) begin
              state <= OWNED;
            end else begin
              state   <= IDLE;
              grant_q <= '0;
              pointer <= adv_ptr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_pipeline_arbiter.sv
// Self-checking bench for wishbone_pipeline_arbiter: reset, routing, round-robin, window limit, LOCK, watchdog.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled 1 unit later.
// Backpressure: target stall and outstanding-limit stalls exercised directly.
module tb_wishbone_pipeline_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int SW = 1;
  localparam int MO = 4;
  localparam int TO = 8;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    I_CYC, I_STB, I_WE, I_LOCK;
  logic [N*AW-1:0] I_ADDR;
  logic [N*DW-1:0] I_DAT_ToTarget;
  logic [N*SW-1:0] I_SEL;
  logic [N-1:0]    I_STALL, I_ACK, I_ERR, I_RTY;
  logic [DW-1:0]   I_DAT_ToInitiator;
  logic            T_CYC, T_STB, T_WE, T_LOCK;
  logic [AW-1:0]   T_ADDR;
  logic [DW-1:0]   T_DAT_ToTarget;
  logic [SW-1:0]   T_SEL;
  logic            T_STALL, T_ACK, T_ERR, T_RTY;
  logic [DW-1:0]   T_DAT_ToInitiator;
  logic [N-1:0]    Grant;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [N-1:0] ack;
    logic [N-1:0] err;
    logic [N-1:0] rty;
  } resp_t;

  resp_t exp_q[$];

  wishbone_pipeline_arbiter #(
    .Initiators(N), .AddressWidth(AW), .DataWidth(DW), .Granularity(8),
    .MaxOutstanding(MO), .Timeout(TO)
  ) dut (
    .CLK(CLK), .RST(RST),
    .I_CYC(I_CYC), .I_STB(I_STB), .I_WE(I_WE), .I_LOCK(I_LOCK),
    .I_ADDR(I_ADDR), .I_DAT_ToTarget(I_DAT_ToTarget), .I_SEL(I_SEL),
    .I_STALL(I_STALL), .I_ACK(I_ACK), .I_ERR(I_ERR), .I_RTY(I_RTY),
    .I_DAT_ToInitiator(I_DAT_ToInitiator),
    .T_CYC(T_CYC), .T_STB(T_STB), .T_WE(T_WE), .T_LOCK(T_LOCK),
    .T_ADDR(T_ADDR), .T_DAT_ToTarget(T_DAT_ToTarget), .T_SEL(T_SEL),
    .T_STALL(T_STALL), .T_ACK(T_ACK), .T_ERR(T_ERR), .T_RTY(T_RTY),
    .T_DAT_ToInitiator(T_DAT_ToInitiator),
    .Grant(Grant)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs;
    I_CYC = '0; I_STB = '0; I_WE = '0; I_LOCK = '0;
    I_ADDR = '0; I_DAT_ToTarget = '0; I_SEL = '0;
    T_STALL = 1'b0; T_ACK = 1'b0; T_ERR = 1'b0; T_RTY = 1'b0;
    T_DAT_ToInitiator = '0;
  endtask

  task automatic reset_dut;
    idle_inputs();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    RST = 1'b1;
    I_CYC = 4'hF;
    T_ACK = 1'b1;
    tick();
    #1;
    checks++;
    if (Grant !== 4'b0 || T_CYC !== 1'b0 || T_STB !== 1'b0 || T_LOCK !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: Grant=%b T_CYC=%b T_STB=%b T_LOCK=%b, want 0000 0 0 0", Grant, T_CYC, T_STB, T_LOCK);
    end
    checks++;
    if (I_STALL !== 4'hF || (I_ACK | I_ERR | I_RTY) !== 4'b0) begin
      errors++;
      $display("FAIL reset_init: I_STALL=%b resp=%b, want 1111 0000", I_STALL, I_ACK | I_ERR | I_RTY);
    end
    RST = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_single;
    resp_t e;
    reset_dut();
    for (int k = 0; k < N; k++) begin
      I_ADDR[k*AW +: AW]         = 16'hA000 + 16'(k);
      I_DAT_ToTarget[k*DW +: DW] = 8'h10 + 8'(k);
    end
    I_WE  = 4'b0100;
    I_SEL = 4'b0100;
    I_CYC = 4'b0100;
    #1;
    checks++;
    if (Grant !== 4'b0 || T_CYC !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: Grant=%b T_CYC=%b, want 0000 0", Grant, T_CYC);
    end
    tick();
    checks++;
    if (Grant !== 4'b0100 || T_CYC !== 1'b1 || I_STALL !== 4'b1011) begin
      errors++;
      $display("FAIL single_grant: Grant=%b T_CYC=%b I_STALL=%b, want 0100 1 1011", Grant, T_CYC, I_STALL);
    end
    checks++;
    if (T_ADDR !== 16'hA002 || T_DAT_ToTarget !== 8'h12 || T_WE !== 1'b1 || T_SEL !== 1'b1) begin
      errors++;
      $display("FAIL single_mux: addr=%h dat=%h we=%b sel=%b, want a002 12 1 1", T_ADDR, T_DAT_ToTarget, T_WE, T_SEL);
    end
    I_STB   = 4'b0100;
    T_STALL = 1'b1;
    #1;
    checks++;
    if (T_STB !== 1'b1 || I_STALL !== 4'hF) begin
      errors++;
      $display("FAIL single_tstall: T_STB=%b I_STALL=%b, want 1 1111", T_STB, I_STALL);
    end
    tick();
    T_STALL = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (T_STB !== 1'b1 || I_STALL !== 4'b1011) begin
        errors++;
        $display("FAIL single_stb%0d: T_STB=%b I_STALL=%b, want 1 1011", i, T_STB, I_STALL);
      end
      tick();
    end
    I_STB = '0;
    for (int i = 0; i < 3; i++) begin
      T_ACK = (i == 0);
      T_ERR = (i == 1);
      T_RTY = (i == 2);
      T_DAT_ToInitiator = 8'h30 + 8'(i);
      e.ack = (i == 0) ? 4'b0100 : 4'b0;
      e.err = (i == 1) ? 4'b0100 : 4'b0;
      e.rty = (i == 2) ? 4'b0100 : 4'b0;
      exp_q.push_back(e);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({I_ACK, I_ERR, I_RTY} !== e || I_DAT_ToInitiator !== 8'h30 + 8'(i)) begin
        errors++;
        $display("FAIL single_resp%0d: ack=%b err=%b rty=%b dat=%h, want ack=%b err=%b rty=%b dat=%h",
                 i, I_ACK, I_ERR, I_RTY, I_DAT_ToInitiator, e.ack, e.err, e.rty, 8'h30 + 8'(i));
      end
      tick();
    end
    T_ACK = 1'b1; T_ERR = 1'b0; T_RTY = 1'b0;
    exp_q.push_back('0);
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({I_ACK, I_ERR, I_RTY} !== e) begin
      errors++;
      $display("FAIL single_stray: ack=%b err=%b rty=%b, want all zero", I_ACK, I_ERR, I_RTY);
    end
    tick();
    T_ACK = 1'b0;
    I_CYC = '0;
    #1;
    checks++;
    if (T_CYC !== 1'b0) begin
      errors++;
      $display("FAIL single_cycdrop: T_CYC=%b, want 0", T_CYC);
    end
    tick();
    checks++;
    if (Grant !== 4'b0) begin
      errors++;
      $display("FAIL single_release: Grant=%b, want 0000", Grant);
    end
  endtask

  task automatic test_round_robin;
    resp_t e;
    int seq[3];
    logic [N-1:0] want;
    seq = '{0, 3, 0};
    reset_dut();
    for (int k = 0; k < 3; k++) begin
      want  = 4'b0001 << seq[k];
      I_CYC = 4'b1001;
      tick();
      checks++;
      if (Grant !== want) begin
        errors++;
        $display("FAIL rr_grant%0d: Grant=%b, want %b", k, Grant, want);
      end
      I_STB = want;
      tick();
      I_STB = '0;
      T_ACK = 1'b1;
      e.ack = want; e.err = '0; e.rty = '0;
      exp_q.push_back(e);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({I_ACK, I_ERR, I_RTY} !== e || Grant !== want) begin
        errors++;
        $display("FAIL rr_ack%0d: ack=%b err=%b rty=%b Grant=%b, want ack=%b Grant=%b", k, I_ACK, I_ERR, I_RTY, Grant, e.ack, want);
      end
      tick();
      T_ACK = 1'b0;
      I_CYC = 4'b1001 & ~want;
      tick();
      checks++;
      if (Grant !== 4'b0) begin
        errors++;
        $display("FAIL rr_release%0d: Grant=%b, want 0000", k, Grant);
      end
    end
    I_CYC = '0;
    tick();
  endtask

  task automatic test_max_outstanding;
    resp_t e;
    reset_dut();
    I_CYC = 4'b0010;
    tick();
    I_STB = 4'b0010;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (T_STB !== (c < 4) || I_STALL !== ((c < 4) ? 4'b1101 : 4'b1111)) begin
        errors++;
        $display("FAIL max_window%0d: T_STB=%b I_STALL=%b, want %b %b", c, T_STB, I_STALL, (c < 4), (c < 4) ? 4'b1101 : 4'b1111);
      end
      tick();
    end
    T_ACK = 1'b1;
    e.ack = 4'b0010; e.err = '0; e.rty = '0;
    exp_q.push_back(e);
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({I_ACK, I_ERR, I_RTY} !== e || T_STB !== 1'b0) begin
      errors++;
      $display("FAIL max_ack: ack=%b err=%b rty=%b T_STB=%b, want ack=%b T_STB=0", I_ACK, I_ERR, I_RTY, T_STB, e.ack);
    end
    tick();
    T_ACK = 1'b0;
    #1;
    checks++;
    if (T_STB !== 1'b1 || I_STALL !== 4'b1101) begin
      errors++;
      $display("FAIL max_fifth: T_STB=%b I_STALL=%b, want 1 1101", T_STB, I_STALL);
    end
    tick();
    I_STB = '0;
    I_CYC = '0;
    tick();
  endtask

  task automatic test_lock;
    reset_dut();
    I_CYC  = 4'b0010;
    I_LOCK = 4'b0010;
    tick();
    checks++;
    if (Grant !== 4'b0010 || T_LOCK !== 1'b1) begin
      errors++;
      $display("FAIL lock_grant: Grant=%b T_LOCK=%b, want 0010 1", Grant, T_LOCK);
    end
    I_CYC = 4'b0011;
    tick();
    I_CYC = 4'b0001;
    #1;
    checks++;
    if (T_CYC !== 1'b0) begin
      errors++;
      $display("FAIL lock_cycdrop: T_CYC=%b, want 0", T_CYC);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (Grant !== 4'b0010 || T_CYC !== 1'b0 || I_STALL !== 4'hF) begin
        errors++;
        $display("FAIL lock_hold%0d: Grant=%b T_CYC=%b I_STALL=%b, want 0010 0 1111", c, Grant, T_CYC, I_STALL);
      end
      tick();
    end
    I_CYC = 4'b0011;
    tick();
    checks++;
    if (Grant !== 4'b0010 || T_CYC !== 1'b1 || I_STALL !== 4'b1101) begin
      errors++;
      $display("FAIL lock_reown: Grant=%b T_CYC=%b I_STALL=%b, want 0010 1 1101", Grant, T_CYC, I_STALL);
    end
    I_CYC = 4'b0001;
    tick();
    I_LOCK = '0;
    #1;
    checks++;
    if (Grant !== 4'b0010) begin
      errors++;
      $display("FAIL lock_relock: Grant=%b, want 0010", Grant);
    end
    tick();
    checks++;
    if (Grant !== 4'b0) begin
      errors++;
      $display("FAIL lock_unlock: Grant=%b, want 0000", Grant);
    end
    tick();
    checks++;
    if (Grant !== 4'b0001) begin
      errors++;
      $display("FAIL lock_next: Grant=%b, want 0001", Grant);
    end
    I_CYC = '0;
    tick();
  endtask

  task automatic test_watchdog;
    resp_t e;
    reset_dut();
    I_CYC = 4'b0100;
    tick();
    I_STB = 4'b0100;
    tick();
    tick();
    I_STB = '0;
    for (int c = 0; c < TO; c++) begin
      #1;
      checks++;
      if (T_CYC !== 1'b1) begin
        errors++;
        $display("FAIL wd_wait%0d: T_CYC=%b, want 1", c, T_CYC);
      end
      tick();
    end
    T_ACK = 1'b1;
    for (int c = 0; c < 2; c++) begin
      e.ack = '0; e.err = 4'b0100; e.rty = '0;
      exp_q.push_back(e);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({I_ACK, I_ERR, I_RTY} !== e || T_CYC !== 1'b0 || T_STB !== 1'b0 || I_STALL !== 4'hF) begin
        errors++;
        $display("FAIL wd_abort%0d: ack=%b err=%b rty=%b T_CYC=%b I_STALL=%b, want err=0100 T_CYC=0 I_STALL=1111",
                 c, I_ACK, I_ERR, I_RTY, T_CYC, I_STALL);
      end
      tick();
    end
    exp_q.push_back('0);
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({I_ACK, I_ERR, I_RTY} !== e || T_CYC !== 1'b1) begin
      errors++;
      $display("FAIL wd_late: ack=%b err=%b rty=%b T_CYC=%b, want all zero and T_CYC=1", I_ACK, I_ERR, I_RTY, T_CYC);
    end
    tick();
    T_ACK = 1'b0;
    I_CYC = '0;
    tick();
  endtask

  task automatic test_reset_mid;
    resp_t e;
    reset_dut();
    I_CYC = 4'b0001;
    tick();
    I_STB = 4'b0001;
    tick();
    tick();
    tick();
    I_STB = '0;
    RST = 1'b1;
    tick();
    checks++;
    if (Grant !== 4'b0 || T_CYC !== 1'b0 || I_STALL !== 4'hF) begin
      errors++;
      $display("FAIL rst_mid: Grant=%b T_CYC=%b I_STALL=%b, want 0000 0 1111", Grant, T_CYC, I_STALL);
    end
    RST = 1'b0;
    tick();
    T_ACK = 1'b1;
    exp_q.push_back('0);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (Grant !== 4'b0001 || {I_ACK, I_ERR, I_RTY} !== e) begin
      errors++;
      $display("FAIL rst_cleared: Grant=%b ack=%b err=%b rty=%b, want 0001 and no response", Grant, I_ACK, I_ERR, I_RTY);
    end
    tick();
    T_ACK = 1'b0;
    I_CYC = '0;
    tick();
  endtask

  // Scenario sequence.
  initial begin
    RST = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_max_outstanding();
    test_lock();
    test_watchdog();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
